// File: rtl/mips_cpu_bus_lsu_if.sv
// Request/response and Avalon-MM bus bundle of the MIPS bus access unit.
// The master modport is the unit; the slave modport is the core plus memory side.
interface mips_cpu_bus_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  // Request: accepted on a cycle with req_valid && req_ready.
  // Response: resp_valid is a one-cycle pulse with no backpressure.
  modport master (
    input  req_valid, req_kind, req_size, req_signed, req_addr, req_wdata,
    input  waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_kind, req_size, req_signed, req_addr, req_wdata,
    output waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
    input  address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_cpu_bus_lsu.sv
// Avalon-MM bus access unit for the multicycle MIPS core: one fetch/load/store
// at a time, lane alignment, sub-word extension, fixed read latency, timeout.
module mips_cpu_bus_lsu #(
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 0,
  parameter bit          BIG_ENDIAN   = 1'b0,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_cpu_bus_lsu_if.master        bus,
  output logic [1:0]                dbg_state
);
  localparam logic [3:0]  LAT = READ_LATENCY[3:0];
  localparam logic [15:0] TO  = TIMEOUT[15:0];

  typedef enum logic [1:0] {IDLE, ACCESS, LATENCY, RESP} state_t;

  state_t      state;
  logic        is_write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [3:0]  lat_cnt;
  logic [15:0] to_cnt;

  logic [1:0]  eff_size;
  logic        misaligned;
  logic [1:0]  lane;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign bus.busy      = (state != IDLE);
  assign bus.req_ready = (state == IDLE);
  assign dbg_state     = state;

  // Fetch is always a word; size 11 behaves as a word as well.
  always_comb begin
    eff_size   = (bus.req_kind == 2'b00) ? 2'b10 : bus.req_size;
    misaligned = ((eff_size == 2'b01) && bus.req_addr[0]) ||
                 (eff_size[1] && (bus.req_addr[1:0] != 2'b00));
    lane       = 2'b00;
    be_next    = 4'hF;
    wd_next    = bus.req_wdata;
    case (eff_size)
      2'b00: begin
        lane    = BIG_ENDIAN ? ~bus.req_addr[1:0] : bus.req_addr[1:0];
        be_next = 4'b0001 << lane;
        wd_next = {24'h0, bus.req_wdata[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        lane    = {(BIG_ENDIAN ? ~bus.req_addr[1] : bus.req_addr[1]), 1'b0};
        be_next = 4'b0011 << lane;
        wd_next = {16'h0, bus.req_wdata[15:0]} << {lane, 3'b000};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = bus.readdata >> {lane_q, 3'b000};
    load_data = bus.readdata;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 2'b00;
      bus.resp_rdata <= '0;
      bus.writedata  <= '0;
      bus.byteenable <= 4'hF;
      bus.address    <= RESET_VECTOR;
      is_write_q     <= 1'b0;
      size_q         <= 2'b10;
      signed_q       <= 1'b0;
      lane_q         <= 2'b00;
      lat_cnt        <= '0;
      to_cnt         <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            size_q     <= eff_size;
            signed_q   <= bus.req_signed;
            lane_q     <= lane;
            is_write_q <= (bus.req_kind == 2'b10);
            if (misaligned) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 2'b01;
              bus.resp_rdata <= '0;
            end else begin
              state          <= ACCESS;
              bus.address    <= {bus.req_addr[31:2], 2'b00};
              bus.byteenable <= be_next;
              bus.writedata  <= wd_next;
              bus.read       <= (bus.req_kind != 2'b10);
              bus.write      <= (bus.req_kind == 2'b10);
              lat_cnt        <= 4'd1;
              to_cnt         <= '0;
            end
          end
        end
        ACCESS: begin
          lat_cnt <= lat_cnt + 4'd1;
          // Completion has priority over a timeout hitting in the same cycle.
          if (!bus.waitrequest) begin
            bus.read  <= 1'b0;
            bus.write <= 1'b0;
            if (is_write_q) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 2'b00;
              bus.resp_rdata <= '0;
            end else if ((READ_LATENCY == 0) || (lat_cnt == LAT)) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 2'b00;
              bus.resp_rdata <= load_data;
            end else begin
              state <= LATENCY;
            end
          end else if ((TIMEOUT != 0) && ((to_cnt + 16'd1) == TO)) begin
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 2'b10;
            bus.resp_rdata <= '0;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        LATENCY: begin
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_cnt == LAT) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 2'b00;
            bus.resp_rdata <= load_data;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// Bench for mips_cpu_bus_lsu: an LE/L=0/TIMEOUT=4 instance and a BE/L=3 instance,
// driven from a vector table with a response scoreboard.
module tb_mips_cpu_bus_lsu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mips_cpu_bus_lsu_if if_a ();
  mips_cpu_bus_lsu_if if_b ();
  logic [1:0] dbg_a, dbg_b;

  mips_cpu_bus_lsu #(.READ_LATENCY(0), .TIMEOUT(4), .BIG_ENDIAN(1'b0)) u_a (
    .clk(clk), .reset(reset), .bus(if_a), .dbg_state(dbg_a));
  mips_cpu_bus_lsu #(.READ_LATENCY(3), .TIMEOUT(0), .BIG_ENDIAN(1'b1)) u_b (
    .clk(clk), .reset(reset), .bus(if_b), .dbg_state(dbg_b));

  // Shared stimulus; req_valid only reaches the selected instance.
  int          cur = 0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_kind = 2'b00, req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, readdata = '0;
  logic        waitrequest = 1'b0;

  assign if_a.req_valid = req_valid && (cur == 0);
  assign if_b.req_valid = req_valid && (cur == 1);
  assign if_a.req_kind = req_kind;     assign if_b.req_kind = req_kind;
  assign if_a.req_size = req_size;     assign if_b.req_size = req_size;
  assign if_a.req_signed = req_signed; assign if_b.req_signed = req_signed;
  assign if_a.req_addr = req_addr;     assign if_b.req_addr = req_addr;
  assign if_a.req_wdata = req_wdata;   assign if_b.req_wdata = req_wdata;
  assign if_a.waitrequest = waitrequest; assign if_b.waitrequest = waitrequest;
  assign if_a.readdata = readdata;     assign if_b.readdata = readdata;

  logic        o_ready, o_rv, o_busy, o_read, o_write;
  logic [31:0] o_rdata, o_addr, o_wd;
  logic [1:0]  o_err, o_dbg;
  logic [3:0]  o_be;

  always_comb begin
    if (cur == 0) begin
      o_ready = if_a.req_ready; o_rv = if_a.resp_valid; o_busy = if_a.busy;
      o_read = if_a.read; o_write = if_a.write; o_rdata = if_a.resp_rdata;
      o_addr = if_a.address; o_wd = if_a.writedata; o_err = if_a.resp_err;
      o_be = if_a.byteenable; o_dbg = dbg_a;
    end else begin
      o_ready = if_b.req_ready; o_rv = if_b.resp_valid; o_busy = if_b.busy;
      o_read = if_b.read; o_write = if_b.write; o_rdata = if_b.resp_rdata;
      o_addr = if_b.address; o_wd = if_b.writedata; o_err = if_b.resp_err;
      o_be = if_b.byteenable; o_dbg = dbg_b;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: {resp_rdata, resp_err, cycle of resp_valid}.
  logic [49:0] exp_q[$];

  always @(negedge clk) begin
    if (o_rv) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp_valid", 64'd1, 64'd0);
      end else begin
        logic [49:0] e;
        e = exp_q.pop_front();
        check("resp_rdata", 64'(o_rdata), 64'(e[49:18]));
        check("resp_err", 64'(o_err), 64'(e[17:16]));
        check("resp_cycle", 64'(cyc[15:0]), 64'(e[15:0]));
      end
    end
  end

  typedef struct {
    int          sel;
    logic [1:0]  kind;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic [1:0]  err;
    int          lat;
    int          strobes;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int sel, logic [1:0] kind, logic [1:0] size, logic sgn,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              int stalls, logic [3:0] be, logic [31:0] wd,
                              logic [31:0] exp_rdata, logic [1:0] err, int lat, int strobes);
    vec_t v;
    v.sel = sel; v.kind = kind; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.stalls = stalls; v.be = be; v.wd = wd;
    v.exp_rdata = exp_rdata; v.err = err; v.lat = lat; v.strobes = strobes;
    return v;
  endfunction

  // Called right after a rising edge (cycle 0); returns in cycle lat+1.
  task automatic run_txn(input vec_t v);
    int c0;
    int strobes;
    cur = v.sel;
    #0;
    check("req_ready_before", 64'(o_ready), 64'd1);
    req_kind = v.kind; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    waitrequest = 1'b0;
    readdata = 32'hDEADBEEF;
    c0 = cyc;
    exp_q.push_back({v.exp_rdata, v.err, 16'(c0 + v.lat)});
    strobes = 0;
    for (int n = 1; n <= v.lat; n++) begin
      @(posedge clk); #1;
      req_valid   = 1'b0;
      waitrequest = (n <= v.stalls);
      readdata    = (v.sel == 1 && n != 3) ? 32'hDEADBEEF : v.rdata;
      if (o_read || o_write) begin
        strobes++;
        check("read_strobe", 64'(o_read), 64'(v.kind != 2'b10));
        check("write_strobe", 64'(o_write), 64'(v.kind == 2'b10));
        check("address", 64'(o_addr), 64'({v.addr[31:2], 2'b00}));
        check("byteenable", 64'(o_be), 64'(v.be));
        if (v.kind == 2'b10) check("writedata", 64'(o_wd), 64'(v.wd));
      end
    end
    check("strobe_cycles", 64'(strobes), 64'(v.strobes));
    @(posedge clk); #1;
    waitrequest = 1'b0;
    check("busy_after", 64'(o_busy), 64'd0);
    check("req_ready_after", 64'(o_ready), 64'd1);
  endtask

  initial begin
    // LE, L=0, TIMEOUT=4 instance
    vecs.push_back(mk(0, 2'b01, 2'b00, 1, 32'h1003, 0, 32'h80123456, 0, 4'b1000, 0, 32'hFFFFFF80, 2'b00, 2, 1));
    vecs.push_back(mk(0, 2'b01, 2'b00, 0, 32'h1001, 0, 32'h0000A500, 0, 4'b0010, 0, 32'h000000A5, 2'b00, 2, 1));
    vecs.push_back(mk(0, 2'b01, 2'b01, 1, 32'h1002, 0, 32'hC0DE1234, 2, 4'b1100, 0, 32'hFFFFC0DE, 2'b00, 4, 3));
    vecs.push_back(mk(0, 2'b01, 2'b01, 0, 32'h1000, 0, 32'h1234F00D, 0, 4'b0011, 0, 32'h0000F00D, 2'b00, 2, 1));
    vecs.push_back(mk(0, 2'b01, 2'b10, 1, 32'h2000, 0, 32'h89ABCDEF, 0, 4'b1111, 0, 32'h89ABCDEF, 2'b00, 2, 1));
    vecs.push_back(mk(0, 2'b10, 2'b00, 0, 32'h3002, 32'h123456AB, 32'h55555555, 0, 4'b0100, 32'h00AB0000, 0, 2'b00, 2, 1));
    vecs.push_back(mk(0, 2'b10, 2'b01, 0, 32'h3000, 32'hFFFFBEEF, 0, 1, 4'b0011, 32'h0000BEEF, 0, 2'b00, 3, 2));
    vecs.push_back(mk(0, 2'b10, 2'b10, 0, 32'h3004, 32'hCAFEF00D, 0, 0, 4'b1111, 32'hCAFEF00D, 0, 2'b00, 2, 1));
    vecs.push_back(mk(0, 2'b01, 2'b10, 0, 32'h1001, 0, 32'h11111111, 0, 4'hF, 0, 0, 2'b01, 1, 0));
    vecs.push_back(mk(0, 2'b10, 2'b01, 0, 32'h1003, 32'h1234, 0, 0, 4'hF, 0, 0, 2'b01, 1, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 32'h0040, 0, 32'h24020005, 0, 4'b1111, 0, 32'h24020005, 2'b00, 2, 1));
    vecs.push_back(mk(0, 2'b01, 2'b10, 0, 32'h4000, 0, 32'h12345678, 100, 4'b1111, 0, 0, 2'b10, 5, 4));
    vecs.push_back(mk(0, 2'b01, 2'b10, 0, 32'h4004, 0, 32'h0BADF00D, 3, 4'b1111, 0, 32'h0BADF00D, 2'b00, 5, 4));
    vecs.push_back(mk(0, 2'b11, 2'b00, 1, 32'h1000, 0, 32'hFFFFFF7F, 0, 4'b0001, 0, 32'h0000007F, 2'b00, 2, 1));
    vecs.push_back(mk(0, 2'b00, 2'b10, 0, 32'h0042, 0, 32'h24020005, 0, 4'hF, 0, 0, 2'b01, 1, 0));
    // BE, L=3, no timeout instance
    vecs.push_back(mk(1, 2'b10, 2'b01, 0, 32'h2002, 32'h0000BEEF, 0, 0, 4'b0011, 32'h0000BEEF, 0, 2'b00, 2, 1));
    vecs.push_back(mk(1, 2'b10, 2'b01, 0, 32'h2002, 32'h0000BEEF, 0, 3, 4'b0011, 32'h0000BEEF, 0, 2'b00, 5, 4));
    vecs.push_back(mk(1, 2'b00, 2'b10, 0, 32'hBFC00000, 0, 32'h24020005, 0, 4'b1111, 0, 32'h24020005, 2'b00, 4, 1));
    vecs.push_back(mk(1, 2'b01, 2'b00, 0, 32'h1000, 0, 32'h5A000000, 0, 4'b1000, 0, 32'h0000005A, 2'b00, 4, 1));
    vecs.push_back(mk(1, 2'b01, 2'b01, 1, 32'h1000, 0, 32'h9ABC0000, 1, 4'b1100, 0, 32'hFFFF9ABC, 2'b00, 4, 2));
    vecs.push_back(mk(1, 2'b10, 2'b00, 0, 32'h2001, 32'h00000077, 0, 0, 4'b0100, 32'h00770000, 0, 2'b00, 2, 1));

    // Reset values on both instances
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      cur = s;
      #1;
      check("rst_read", 64'(o_read), 64'd0);
      check("rst_write", 64'(o_write), 64'd0);
      check("rst_resp_valid", 64'(o_rv), 64'd0);
      check("rst_resp_err", 64'(o_err), 64'd0);
      check("rst_resp_rdata", 64'(o_rdata), 64'd0);
      check("rst_writedata", 64'(o_wd), 64'd0);
      check("rst_byteenable", 64'(o_be), 64'hF);
      check("rst_address", 64'(o_addr), 64'hBFC00000);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_req_ready", 64'(o_ready), 64'd1);
      check("rst_state", 64'(o_dbg), 64'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

    // Reset in the middle of a stalled store: no response may follow.
    cur = 0;
    req_kind = 2'b10; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h5000; req_wdata = 32'h11112222;
    req_valid = 1'b1; waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midrst_write_high", 64'(o_write), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    waitrequest = 1'b0;
    check("midrst_read", 64'(o_read), 64'd0);
    check("midrst_write", 64'(o_write), 64'd0);
    check("midrst_address", 64'(o_addr), 64'hBFC00000);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_resp_valid", 64'(o_rv), 64'd0);
    @(posedge clk); #1;
    run_txn(vecs[0]);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
